// File: rtl/ctrl_teclado_pkg.sv
// Shared definitions for the PS/2 keyboard control machine: state encoding,
// scan-code constants and the packed lookup tables used by scan_digit_dec.
package ctrl_teclado_pkg;

  typedef enum logic [1:0] {
    APAG      = 2'd0,
    ENC       = 2'd1,
    APAG_SKIP = 2'd2,
    ENC_SKIP  = 2'd3
  } state_e;

  localparam logic [7:0] KEY_ON  = 8'h24;  // 'E'
  localparam logic [7:0] KEY_OFF = 8'h1C;  // 'A'
  localparam logic [7:0] BRK     = 8'hF0;
  localparam logic [7:0] EXT     = 8'hE0;

  localparam logic [7:0] KEY_T = 8'h2C;
  localparam logic [7:0] KEY_P = 8'h4D;
  localparam logic [7:0] KEY_Q = 8'h15;
  localparam logic [7:0] KEY_W = 8'h1D;

  // Entry i of a table lives at [i*8 +: 8] and decodes to index i.
  localparam int unsigned N_DIGITS = 10;
  localparam logic [N_DIGITS*8-1:0] DIGIT_CODES = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  localparam int unsigned N_SEL = 4;
  localparam logic [N_SEL*8-1:0] SEL_CODES = {KEY_W, KEY_Q, KEY_P, KEY_T};

endpackage

// File: rtl/scan_digit_dec.sv
// Combinational scan-code lookup: reports whether a byte is in CODES and its
// table index. Used for both the digit keys and the channel-select keys.
module scan_digit_dec
  import ctrl_teclado_pkg::*;
#(
  parameter int unsigned              N_CODES = N_DIGITS,
  parameter logic [N_CODES*8-1:0]     CODES   = DIGIT_CODES
) (
  input  logic [7:0] code,
  output logic       is_digit,
  output logic [3:0] digit
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    is_digit = 1'b0;
    digit    = 4'd0;
    for (int i = 0; i < int'(N_CODES); i++) begin
      if (code == CODES[i*8 +: 8]) begin
        is_digit = 1'b1;
        digit    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ctrl_teclado_param.sv
// Keyboard control machine: on/off FSM with break/extended prefix skipping and
// N_CH digit-written setpoint registers. Define IDLE_OFF_EN for auto power-off.
module ctrl_teclado_param
  import ctrl_teclado_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int VAL_W    = 3,
  parameter int VAL_MAX  = 6,
  parameter int IDLE_CYC = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tecla_valid,
  input  logic [7:0]            tecla,
  output logic                  EN,
  output logic [1:0]            ch_sel,
  output logic [N_CH*VAL_W-1:0] vals,
  output logic                  wr_stb,
  output logic [1:0]            wr_ch,
  output logic                  err_stb
);

  localparam logic [3:0] N_CH_L    = 4'(N_CH);
  localparam logic [3:0] VAL_MAX_L = 4'(VAL_MAX);

  state_e                state_q;
  logic                  en_q;
  logic [1:0]            ch_sel_q;
  logic [N_CH*VAL_W-1:0] vals_q;
  logic                  wr_stb_q;
  logic [1:0]            wr_ch_q;
  logic                  err_stb_q;

  logic       dig_hit;
  logic [3:0] dig_val;
  logic       sel_hit;
  logic [3:0] sel_idx;
  logic       idle_expire;

  scan_digit_dec #(
    .N_CODES (N_DIGITS),
    .CODES   (DIGIT_CODES)
  ) u_dig_dec (
    .code     (tecla),
    .is_digit (dig_hit),
    .digit    (dig_val)
  );

  scan_digit_dec #(
    .N_CODES (N_SEL),
    .CODES   (SEL_CODES)
  ) u_sel_dec (
    .code     (tecla),
    .is_digit (sel_hit),
    .digit    (sel_idx)
  );

`ifdef IDLE_OFF_EN
  localparam int              CNT_W     = $clog2(IDLE_CYC);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] idle_d;
  logic             in_enc;

  assign in_enc      = (state_q == ENC) || (state_q == ENC_SKIP);
  assign idle_expire = in_enc && !tecla_valid && (idle_q == IDLE_LAST);

  always_comb begin
    idle_d = idle_q + 1'b1;
    if (tecla_valid || !in_enc || idle_expire) idle_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  assign idle_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the setpoint bank is plain flops cleared by reset, not a RAM.
    if (!reset_n) begin
      state_q   <= APAG;
      en_q      <= 1'b0;
      ch_sel_q  <= 2'd0;
      vals_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_ch_q   <= 2'd0;
      err_stb_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments override the strobe defaults.
      wr_stb_q  <= 1'b0;
      err_stb_q <= 1'b0;
      if (tecla_valid) begin
        unique case (state_q)
          APAG: begin
            if (tecla == KEY_ON) begin
              state_q <= ENC;
              en_q    <= 1'b1;
            end else if (tecla == BRK || tecla == EXT) begin
              state_q <= APAG_SKIP;
            end
          end
          APAG_SKIP: state_q <= APAG;
          ENC_SKIP:  state_q <= ENC;
          ENC: begin
            if (tecla == KEY_OFF) begin
              state_q  <= APAG;
              en_q     <= 1'b0;
              vals_q   <= '0;
              ch_sel_q <= 2'd0;
            end else if (tecla == BRK || tecla == EXT) begin
              state_q <= ENC_SKIP;
            end else if (sel_hit) begin
              if (sel_idx < N_CH_L) ch_sel_q <= sel_idx[1:0];
            end else if (dig_hit) begin
              if (dig_val <= VAL_MAX_L) begin
                vals_q[int'(ch_sel_q)*VAL_W +: VAL_W] <= VAL_W'(dig_val);
                wr_stb_q <= 1'b1;
                wr_ch_q  <= ch_sel_q;
              end else begin
                err_stb_q <= 1'b1;
              end
            end
          end
          default: state_q <= APAG;
        endcase
      end else if (idle_expire) begin
        state_q  <= APAG;
        en_q     <= 1'b0;
        vals_q   <= '0;
        ch_sel_q <= 2'd0;
      end
    end
  end

  assign EN      = en_q;
  assign ch_sel  = ch_sel_q;
  assign vals    = vals_q;
  assign wr_stb  = wr_stb_q;
  assign wr_ch   = wr_ch_q;
  assign err_stb = err_stb_q;

endmodule

// File: tb/tb_ctrl_teclado_param.sv
// Self-checking bench for ctrl_teclado_param: directed vector table, reset and
// idle corner sequences, then random bytes against a behavioural model.
module tb_ctrl_teclado_param;

  localparam int N_CH     = 2;
  localparam int VAL_W    = 3;
  localparam int VAL_MAX  = 6;
  localparam int IDLE_CYC = 16;

  logic                  clk;
  logic                  reset_n;
  logic                  tecla_valid;
  logic [7:0]            tecla;
  logic                  EN;
  logic [1:0]            ch_sel;
  logic [N_CH*VAL_W-1:0] vals;
  logic                  wr_stb;
  logic [1:0]            wr_ch;
  logic                  err_stb;

  ctrl_teclado_param #(
    .N_CH     (N_CH),
    .VAL_W    (VAL_W),
    .VAL_MAX  (VAL_MAX),
    .IDLE_CYC (IDLE_CYC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tecla_valid (tecla_valid),
    .tecla       (tecla),
    .EN          (EN),
    .ch_sel      (ch_sel),
    .vals        (vals),
    .wr_stb      (wr_stb),
    .wr_ch       (wr_ch),
    .err_stb     (err_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Scan codes for digits 0..9 and channel keys T,P,Q,W.
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] sel_codes [4]  = '{8'h2C, 8'h4D, 8'h15, 8'h1D};

  // Behavioural model state.
  bit m_on, m_skip, m_wr, m_err;
  int m_ch, m_wrch, m_idle;
  int m_vals [4];

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic int sel_of(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (sel_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [N_CH*VAL_W-1:0] m_flat();
    logic [N_CH*VAL_W-1:0] f;
    f = '0;
    for (int k = 0; k < N_CH; k++) f[k*VAL_W +: VAL_W] = VAL_W'(m_vals[k]);
    return f;
  endfunction

  task automatic model_reset();
    m_on = 0; m_skip = 0; m_wr = 0; m_err = 0;
    m_ch = 0; m_wrch = 0; m_idle = 0;
    for (int k = 0; k < 4; k++) m_vals[k] = 0;
  endtask

  task automatic model_off();
    m_on = 0; m_skip = 0; m_ch = 0;
    for (int k = 0; k < 4; k++) m_vals[k] = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int d, s;
    m_wr = 0; m_err = 0;
    if (v) begin
      m_idle = 0;
      d = digit_of(b);
      s = sel_of(b);
      if (m_skip) m_skip = 0;
      else if (!m_on) begin
        if (b == 8'h24) m_on = 1;
        else if (b == 8'hF0 || b == 8'hE0) m_skip = 1;
      end else begin
        if (b == 8'h1C) model_off();
        else if (b == 8'hF0 || b == 8'hE0) m_skip = 1;
        else if (s >= 0) begin
          if (s < N_CH) m_ch = s;
        end else if (d >= 0) begin
          if (d <= VAL_MAX) begin
            m_vals[m_ch] = d; m_wr = 1; m_wrch = m_ch;
          end else m_err = 1;
        end
      end
    end
`ifdef IDLE_OFF_EN
    else if (m_on) begin
      if (m_idle == IDLE_CYC - 1) begin
        model_off();
        m_idle = 0;
      end else m_idle++;
    end
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".EN"},      32'(EN),      32'(m_on));
    check({tag, ".ch_sel"},  32'(ch_sel),  32'(m_ch));
    check({tag, ".vals"},    32'(vals),    32'(m_flat()));
    check({tag, ".wr_stb"},  32'(wr_stb),  32'(m_wr));
    check({tag, ".wr_ch"},   32'(wr_ch),   32'(m_wrch));
    check({tag, ".err_stb"}, 32'(err_stb), 32'(m_err));
  endtask

  task automatic apply(input logic v, input logic [7:0] b);
    @(negedge clk);
    tecla_valid = v;
    tecla       = b;
    @(posedge clk);
    #1;
    tecla_valid = 1'b0;
    model_step(v, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       en;
    logic [1:0] ch;
    logic [5:0] vals;
    logic       wr;
    logic [1:0] wrch;
    logic       err;
  } vec_t;

  vec_t tbl [24];

  initial begin
    tbl = '{
      '{1'b1, 8'h24, 1'b1, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},  // power on
      '{1'b1, 8'h2C, 1'b1, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},  // select T
      '{1'b1, 8'h26, 1'b1, 2'd0, 6'h03, 1'b1, 2'd0, 1'b0},  // ch0 = 3
      '{1'b1, 8'h4D, 1'b1, 2'd1, 6'h03, 1'b0, 2'd0, 1'b0},  // select P
      '{1'b1, 8'h36, 1'b1, 2'd1, 6'h33, 1'b1, 2'd1, 1'b0},  // ch1 = 6
      '{1'b1, 8'h3D, 1'b1, 2'd1, 6'h33, 1'b0, 2'd1, 1'b1},  // 7 rejected
      '{1'b1, 8'h15, 1'b1, 2'd1, 6'h33, 1'b0, 2'd1, 1'b0},  // Q ignored
      '{1'b0, 8'h1C, 1'b1, 2'd1, 6'h33, 1'b0, 2'd1, 1'b0},  // not valid
      '{1'b1, 8'hF0, 1'b1, 2'd1, 6'h33, 1'b0, 2'd1, 1'b0},  // break
      '{1'b1, 8'h1C, 1'b1, 2'd1, 6'h33, 1'b0, 2'd1, 1'b0},  // skipped off
      '{1'b1, 8'h2C, 1'b1, 2'd0, 6'h33, 1'b0, 2'd1, 1'b0},
      '{1'b1, 8'h16, 1'b1, 2'd0, 6'h31, 1'b1, 2'd0, 1'b0},  // ch0 = 1
      '{1'b1, 8'hF0, 1'b1, 2'd0, 6'h31, 1'b0, 2'd0, 1'b0},
      '{1'b1, 8'h16, 1'b1, 2'd0, 6'h31, 1'b0, 2'd0, 1'b0},  // release skipped
      '{1'b1, 8'hE0, 1'b1, 2'd0, 6'h31, 1'b0, 2'd0, 1'b0},
      '{1'b1, 8'h1E, 1'b1, 2'd0, 6'h31, 1'b0, 2'd0, 1'b0},
      '{1'b1, 8'h2E, 1'b1, 2'd0, 6'h35, 1'b1, 2'd0, 1'b0},  // ch0 = 5
      '{1'b1, 8'h2E, 1'b1, 2'd0, 6'h35, 1'b1, 2'd0, 1'b0},  // same value
      '{1'b1, 8'h1C, 1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},  // off clears
      '{1'b1, 8'h1E, 1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},  // digit while off
      '{1'b1, 8'hE0, 1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},
      '{1'b1, 8'h24, 1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},  // skipped on
      '{1'b1, 8'h24, 1'b1, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0},
      '{1'b1, 8'h1C, 1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0}
    };

    reset_n     = 1'b0;
    tecla_valid = 1'b0;
    tecla       = 8'h00;
    model_reset();
    #12;
    check("reset.EN",      32'(EN),      32'd0);
    check("reset.ch_sel",  32'(ch_sel),  32'd0);
    check("reset.vals",    32'(vals),    32'd0);
    check("reset.wr_stb",  32'(wr_stb),  32'd0);
    check("reset.err_stb", 32'(err_stb), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].v, tbl[i].code);
      check($sformatf("tbl%0d.EN", i),      32'(EN),      32'(tbl[i].en));
      check($sformatf("tbl%0d.ch_sel", i),  32'(ch_sel),  32'(tbl[i].ch));
      check($sformatf("tbl%0d.vals", i),    32'(vals),    32'(tbl[i].vals));
      check($sformatf("tbl%0d.wr_stb", i),  32'(wr_stb),  32'(tbl[i].wr));
      check($sformatf("tbl%0d.wr_ch", i),   32'(wr_ch),   32'(tbl[i].wrch));
      check($sformatf("tbl%0d.err_stb", i), 32'(err_stb), 32'(tbl[i].err));
    end

    // Reset asserted between edges while in ENC_SKIP.
    do_reset();
    apply(1'b1, 8'h24);
    apply(1'b1, 8'h36);
    apply(1'b1, 8'hF0);
    check_model("pre_rst");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst.EN",   32'(EN),   32'd0);
    check("midrst.vals", 32'(vals), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(1'b1, 8'h24);
    check("post_rst.EN", 32'(EN), 32'd1);
    check_model("post_rst");

    // Idle behaviour.
    do_reset();
    apply(1'b1, 8'h24);
    for (int c = 1; c < IDLE_CYC; c++) apply(1'b0, 8'h00);
    check("idle15.EN", 32'(EN), 32'd1);
    apply(1'b0, 8'h00);
`ifdef IDLE_OFF_EN
    check("idle16.EN", 32'(EN), 32'd0);
`else
    check("idle16.EN", 32'(EN), 32'd1);
`endif
    check_model("idle16");
    apply(1'b1, 8'h24);
    for (int c = 1; c < IDLE_CYC; c++) apply(1'b0, 8'h00);
    apply(1'b1, 8'h12);  // byte lands in the expiry cycle
    check("idle_byte.EN", 32'(EN), 32'd1);
    for (int c = 0; c < 3 * IDLE_CYC; c++) apply(1'b0, 8'h00);
    check_model("idle_long");

    // Randomized bytes against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic       v;
      logic [7:0] b;
      int         pick;
      v    = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 15);
      case (pick)
        0:       b = 8'h24;
        1:       b = 8'h1C;
        2:       b = 8'hF0;
        3:       b = 8'hE0;
        4, 5:    b = sel_codes[$urandom_range(0, 3)];
        14, 15:  b = 8'($urandom_range(0, 255));
        default: b = dig_codes[$urandom_range(0, 9)];
      endcase
      apply(v, b);
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_teclado_param.md
Name: ctrl_teclado_param

Overview:
- Parametrised successor of the keyboard control machine.
- Takes PS/2 scan-code bytes from the keyboard receiver and runs a power on/off state machine.
- Handles break (F0) and extended (E0) prefixes.
- Maintains N_CH independently addressable setpoint registers of VAL_W bits, written by digit keys.
- Feeds the display/actuator stage with registered values plus a write strobe.

Parameters:
- N_CH, 2, number of setpoint channels (legal 1..4); channel 0 = temperature, 1 = pressure.
- VAL_W, 3, bits per setpoint register.
- VAL_MAX, 6, largest digit accepted (must satisfy VAL_MAX ≤ 9 and VAL_MAX < 2**VAL_W).
- IDLE_CYC, 50_000_000, idle cycles before auto power-off (used only with IDLE_OFF_EN).

Ports:
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- tecla_valid, in, 1, one-cycle strobe: tecla holds a new byte
- tecla, in, 8, scan-code byte
- EN, out, 1, machine on
- ch_sel, out, 2, currently selected channel
- vals, out, N_CH*VAL_W, flattened setpoints; channel k at [k*VAL_W +: VAL_W]
- wr_stb, out, 1, one-cycle pulse when a setpoint is written
- wr_ch, out, 2, channel written (valid with wr_stb)
- err_stb, out, 1, one-cycle pulse on rejected digit

Behaviour:
- Reset (async assert, sync deassert by the source):
  - state=APAG; EN=0, ch_sel=0, vals=0, wr_stb=0, wr_ch=0, err_stb=0; idle counter=0.
- Inputs are sampled only when tecla_valid=1; bytes with tecla_valid=0 are ignored.
- All outputs are registered and update on the clk edge that samples the byte (1-cycle latency). Strobes last exactly one cycle.
- State APAG (off):
  - 0x24 ('E') -> ENC, EN=1.
  - 0xF0 or 0xE0 -> APAG_SKIP.
  - Any other byte: no effect.
- State ENC (on):
  - 0x1C ('A') -> APAG; EN=0, vals cleared to 0, ch_sel=0.
  - 0xF0 or 0xE0 -> ENC_SKIP.
  - Channel-select keys 0x2C 'T'=0, 0x4D 'P'=1, 0x15 'Q'=2, 0x1D 'W'=3 set ch_sel. An index ≥ N_CH is ignored.
  - Digit keys 0x45,16,1E,26,25,2E,36,3D,3E,46 = 0..9:
    - If digit ≤ VAL_MAX: vals[ch_sel]=digit, wr_stb=1, wr_ch=ch_sel.
    - Otherwise: value unchanged, err_stb=1.
  - Other bytes: no effect.
- APAG_SKIP / ENC_SKIP: the next valid byte is discarded unconditionally, including 0x24/0x1C/0xF0. State then returns to APAG / ENC respectively.
- Writing a digit equal to the current value still pulses wr_stb.
- A select and a digit never occur in the same cycle (one byte per strobe).

Optional Feature:
- Macro IDLE_OFF_EN.
- Defined:
  - In ENC and ENC_SKIP, a counter increments each cycle and clears on every tecla_valid.
  - When it reaches IDLE_CYC-1 with no valid byte that cycle, the block performs the same action as 0x1C: goes to APAG, EN=0, vals cleared, ch_sel=0.
  - If a valid byte arrives in the expiry cycle, the byte wins and the counter clears.
  - Counter width is $clog2(IDLE_CYC).
- Undefined: no counter logic; the block stays in ENC indefinitely.

Decomposition:
- Package ctrl_teclado_pkg:
  - state encoding (APAG, ENC, APAG_SKIP, ENC_SKIP);
  - scan-code constants (KEY_ON, KEY_OFF, BRK, EXT, channel-select codes);
  - digit code table.
- Sub-module scan_digit_dec: combinational byte -> {is_digit, digit[3:0]}.
  - The same decode pattern is used for the channel-select table.
- FSM, registers and idle counter stay in the top.

Test Plan:
- Power-on: reset, then bytes 0x24, 0x2C, 0x26 -> EN=1 after first byte; after third byte vals[2:0]=3, wr_stb pulse with wr_ch=0.
- Select and limits: ON, then 0x4D, 0x36 -> vals ch1=6, wr_ch=1. Then 0x3D (7) -> err_stb pulse, ch1 stays 6. With N_CH=2, 0x15 -> ch_sel stays 1.
- Break handling: ON, 0x2C, 0x16, 0xF0, 0x16 -> exactly one wr_stb. Then 0xF0, 0x1C -> EN stays 1 because the byte was skipped.
- Off clears state: ON, write ch0=5, then 0x1C -> EN=0, vals=0. Then digit 0x1E while off -> no wr_stb.
- Reset mid-operation: assert reset_n=0 in ENC_SKIP between clock edges -> outputs zero immediately. After release, 0x24 is accepted (not skipped).
- Idle timeout (IDLE_OFF_EN, IDLE_CYC=16):
  - ON, then no bytes for 16 cycles -> EN=0 on cycle 16.
  - Repeat with a byte on cycle 15 -> EN stays 1.
